bus_phase_arbiter: RTL and testbench

Generates the CPU instruction phase strobes FETCH/DECODE/EXECUTE/COMMIT for the bus sequencer and the rest of the core. Shares the memory bus between the CPU and one external bus master (DMA/loader) by granting it only at instruction boundaries. Stretches bus phases while memory holds WAIT_N low. Provides a HALT idle state, and bounds external hold time so the CPU cannot be starved.

---
 rtl/bus_phase_arbiter_pkg.sv | 26 ++
 rtl/bus_phase_arbiter_hold_timer.sv | 27 ++
 rtl/bus_phase_arbiter.sv | 102 ++++++++++
 tb/tb_bus_phase_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_phase_arbiter_pkg.sv
// Shared encodings for the instruction phase sequencer and bus arbiter.
package bus_phase_arbiter_pkg;

  typedef enum logic [2:0] {
    PH_FETCH   = 3'd0,
    PH_DECODE  = 3'd1,
    PH_EXECUTE = 3'd2,
    PH_COMMIT  = 3'd3,
    PH_HOLD    = 3'd4,
    PH_HALTED  = 3'd5
  } phase_t;

  localparam int unsigned BUS_SEQX_W = 2;

  localparam logic [BUS_SEQX_W-1:0] BUS_SEQX_NONE  = 2'd0;
  localparam logic [BUS_SEQX_W-1:0] BUS_SEQX_READ  = 2'd1;
  localparam logic [BUS_SEQX_W-1:0] BUS_SEQX_WRITE = 2'd2;
  localparam logic [BUS_SEQX_W-1:0] BUS_SEQX_RMW   = 2'd3;

  // COMMIT only stretches on WAIT_N when the instruction actually uses the bus.
  function automatic logic commit_stalls(input logic wait_n,
                                         input logic [BUS_SEQX_W-1:0] seqx);
    return !wait_n && (seqx != BUS_SEQX_NONE);
  endfunction

endpackage

// File: rtl/bus_phase_arbiter_hold_timer.sv
// Counts consecutive HOLD cycles and flags the forced-release cycle.
module bus_phase_arbiter_hold_timer #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic CLR,
  output logic EXPIRE
);

  logic [CNT_W-1:0] r_hcnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hcnt <= '0;
    end else if (CLR) begin
      r_hcnt <= '0;
    end else if (EN) begin
      r_hcnt <= r_hcnt + CNT_W'(1);
    end
  end

  assign EXPIRE = (r_hcnt == CNT_W'(MAX_HOLD - 1));

endmodule

// File: rtl/bus_phase_arbiter.sv
// Instruction phase sequencer with boundary-only DMA grants, bounded hold and HALT idle.
module bus_phase_arbiter
  import bus_phase_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WAIT_N,
  input  logic [BUS_SEQX_W-1:0] BUS_SEQX,
  input  logic                  HALT,
  input  logic                  DMA_REQ,
  output logic                  FETCH,
  output logic                  DECODE,
  output logic                  EXECUTE,
  output logic                  COMMIT,
  output logic                  DMA_GNT,
  output logic                  BUS_OWNER,
  output logic                  HALTED
);

  phase_t r_state;
  logic   r_fair;
  logic   r_origin;

  phase_t w_next;
  logic   w_boundary;
  logic   w_hold_exit;
  logic   w_expire;

  bus_phase_arbiter_hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .EN     (r_state == PH_HOLD),
    .CLR    (w_hold_exit),
    .EXPIRE (w_expire)
  );

  always_comb begin
    w_next      = r_state;
    w_boundary  = 1'b0;
    w_hold_exit = 1'b0;
    case (r_state)
      PH_FETCH:   w_next = PH_DECODE;
      PH_DECODE:  if (WAIT_N) w_next = PH_EXECUTE;
      PH_EXECUTE: w_next = PH_COMMIT;
      PH_COMMIT: begin
        if (!commit_stalls(WAIT_N, BUS_SEQX)) begin
          w_boundary = 1'b1;
          if (DMA_REQ && !r_fair) w_next = PH_HOLD;
          else if (HALT)          w_next = PH_HALTED;
          else                    w_next = PH_FETCH;
        end
      end
      PH_HOLD: begin
        if (!DMA_REQ || w_expire) begin
          w_hold_exit = 1'b1;
          w_next      = (HALT && r_origin) ? PH_HALTED : PH_FETCH;
        end
      end
      PH_HALTED: begin
        if (DMA_REQ)    w_next = PH_HOLD;
        else if (!HALT) w_next = PH_FETCH;
      end
      default:    w_next = PH_FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= PH_FETCH;
      r_fair    <= 1'b0;
      r_origin  <= 1'b0;
      FETCH     <= 1'b1;
      DECODE    <= 1'b0;
      EXECUTE   <= 1'b0;
      COMMIT    <= 1'b0;
      DMA_GNT   <= 1'b0;
      BUS_OWNER <= 1'b0;
      HALTED    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hold_exit && (w_next == PH_FETCH)) r_fair <= 1'b1;
      else if (w_boundary)                     r_fair <= 1'b0;
      if ((w_next == PH_HOLD) && (r_state != PH_HOLD))
        r_origin <= (r_state == PH_HALTED);
      FETCH     <= (w_next == PH_FETCH);
      DECODE    <= (w_next == PH_DECODE);
      EXECUTE   <= (w_next == PH_EXECUTE);
      COMMIT    <= (w_next == PH_COMMIT);
      DMA_GNT   <= (w_next == PH_HOLD);
      BUS_OWNER <= (w_next == PH_HOLD);
      HALTED    <= (w_next == PH_HALTED);
    end
  end

endmodule

// File: tb/tb_bus_phase_arbiter.sv
// Directed bench for bus_phase_arbiter: phase sequencing, stretch, grants, HALT and async reset.
module tb_bus_phase_arbiter;
  import bus_phase_arbiter_pkg::*;

  logic       CLK;
  logic       RESET;
  logic       WAIT_N;
  logic [1:0] BUS_SEQX;
  logic       HALT;
  logic       DMA_REQ;
  logic       FETCH, DECODE, EXECUTE, COMMIT, DMA_GNT, BUS_OWNER, HALTED;

  int total;
  int bad;

  // Expected output vectors, order {FETCH,DECODE,EXECUTE,COMMIT,DMA_GNT,BUS_OWNER,HALTED}
  localparam logic [6:0] S_F = 7'b1000000;
  localparam logic [6:0] S_D = 7'b0100000;
  localparam logic [6:0] S_E = 7'b0010000;
  localparam logic [6:0] S_C = 7'b0001000;
  localparam logic [6:0] S_G = 7'b0000110;
  localparam logic [6:0] S_H = 7'b0000001;

  bus_phase_arbiter #(
    .MAX_HOLD (16),
    .CNT_W    (5)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .WAIT_N    (WAIT_N),
    .BUS_SEQX  (BUS_SEQX),
    .HALT      (HALT),
    .DMA_REQ   (DMA_REQ),
    .FETCH     (FETCH),
    .DECODE    (DECODE),
    .EXECUTE   (EXECUTE),
    .COMMIT    (COMMIT),
    .DMA_GNT   (DMA_GNT),
    .BUS_OWNER (BUS_OWNER),
    .HALTED    (HALTED)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp_v);
    logic [6:0] obs;
    obs = {FETCH, DECODE, EXECUTE, COMMIT, DMA_GNT, BUS_OWNER, HALTED};
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Check the current cycle's outputs, then advance one clock; repeated n times.
  task automatic run(input string tag, input logic [6:0] exp_v, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, exp_v);
      tick();
    end
  endtask

  task automatic instr(input string tag);
    run({tag, "_f"}, S_F, 1);
    run({tag, "_d"}, S_D, 1);
    run({tag, "_e"}, S_E, 1);
    run({tag, "_c"}, S_C, 1);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    RESET    = 1'b1;
    WAIT_N   = 1'b1;
    BUS_SEQX = BUS_SEQX_NONE;
    HALT     = 1'b0;
    DMA_REQ  = 1'b0;

    #2;
    chk("reset_hold", S_F);
    tick();
    chk("reset_hold_clk", S_F);
    tick();
    RESET = 1'b0;

    // Free run, period 4
    instr("free0");
    instr("free1");
    instr("free2");

    // DECODE stretched by two WAIT_N=0 cycles
    run("wd_f", S_F, 1);
    WAIT_N = 1'b0;
    run("wd_dstall", S_D, 2);
    WAIT_N = 1'b1;
    run("wd_dlast", S_D, 1);
    run("wd_e", S_E, 1);
    // Non-bus COMMIT ignores WAIT_N
    WAIT_N = 1'b0;
    run("wc_nobus", S_C, 1);
    WAIT_N = 1'b1;

    // Bus COMMIT stretched by one WAIT_N=0 cycle
    run("wcb_f", S_F, 1);
    run("wcb_d", S_D, 1);
    run("wcb_e", S_E, 1);
    BUS_SEQX = BUS_SEQX_READ;
    WAIT_N   = 1'b0;
    run("wcb_stall", S_C, 1);
    WAIT_N   = 1'b1;
    run("wcb_last", S_C, 1);
    BUS_SEQX = BUS_SEQX_NONE;

    // Long DMA: forced release after 16 cycles, fairness, then regrant
    run("dma_f", S_F, 1);
    run("dma_d", S_D, 1);
    run("dma_e", S_E, 1);
    DMA_REQ = 1'b1;
    run("dma_c", S_C, 1);
    run("dma_hold16", S_G, 16);
    instr("fair_instr");
    instr("after_fair");
    run("regrant", S_G, 1);
    DMA_REQ = 1'b0;
    run("regrant_last", S_G, 1);
    instr("clear_fair");

    // Short DMA spanning a boundary
    run("sd_f", S_F, 1);
    run("sd_d", S_D, 1);
    DMA_REQ = 1'b1;
    run("sd_e", S_E, 1);
    run("sd_c", S_C, 1);
    run("sd_g1", S_G, 1);
    DMA_REQ = 1'b0;
    run("sd_g2", S_G, 1);
    instr("sd_after");

    // HALT at a boundary, DMA from HALTED, then resume
    run("h_f", S_F, 1);
    run("h_d", S_D, 1);
    run("h_e", S_E, 1);
    HALT = 1'b1;
    run("h_c", S_C, 1);
    run("h_idle", S_H, 2);
    DMA_REQ = 1'b1;
    run("h_req", S_H, 1);
    run("h_gnt", S_G, 4);
    DMA_REQ = 1'b0;
    run("h_gnt_last", S_G, 1);
    run("h_back", S_H, 2);
    HALT = 1'b0;
    run("h_unhalt", S_H, 1);
    run("h_resume", S_F, 1);
    run("h_resume_d", S_D, 1);
    run("h_resume_e", S_E, 1);

    // DMA and HALT together: DMA wins, then FETCH, HALT honoured next boundary
    HALT    = 1'b1;
    DMA_REQ = 1'b1;
    run("both_c", S_C, 1);
    DMA_REQ = 1'b0;
    run("both_g", S_G, 1);
    instr("both_after");
    run("both_halt", S_H, 1);
    HALT = 1'b0;
    run("both_unhalt", S_H, 1);

    // Async reset in the middle of HOLD
    run("rm_f", S_F, 1);
    run("rm_d", S_D, 1);
    run("rm_e", S_E, 1);
    DMA_REQ = 1'b1;
    run("rm_c", S_C, 1);
    run("rm_g", S_G, 2);
    #3;
    RESET = 1'b1;
    #1;
    chk("rst_async", S_F);
    tick();
    chk("rst_held", S_F);
    RESET = 1'b0;
    // FAIR cleared by reset: first boundary grants immediately
    instr("post_rst");
    run("post_rst_g", S_G, 1);
    DMA_REQ = 1'b0;
    run("post_rst_g2", S_G, 1);
    run("post_rst_f", S_F, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
